// File: rtl/demux_12_2bits_rr_pkg.sv
// Shared encodings and defaults for the 2-bit 1:2 round-robin demultiplexer.
// The guarded defines let other blocks pick up the same lane encodings.
`ifndef DEMUX_12_2BITS_RR_DEFS
`define DEMUX_12_2BITS_RR_DEFS
`define DEMUX_LANE0  1'b0
`define DEMUX_LANE1  1'b1
`define DEMUX_DATA_W 2
`define DEMUX_CNT_W  4
`endif

package demux_12_2bits_rr_pkg;
   localparam int NUM_LANES = 2;

   typedef enum logic {
      LANE0 = `DEMUX_LANE0,
      LANE1 = `DEMUX_LANE1
   } rr_state_e;

   function automatic rr_state_e rr_next(input rr_state_e s);
      return (s == LANE0) ? LANE1 : LANE0;
   endfunction
endpackage

// File: rtl/demux_lane_buffer.sv
// One-entry output buffer for a demux lane: data register, full flag and a
// wrapping count of words handed to the consumer.
module demux_lane_buffer #(
   parameter int DATA_W = `DEMUX_DATA_W,
   parameter int CNT_W  = `DEMUX_CNT_W
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   input  logic              ready_out,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [CNT_W-1:0]  word_count
);
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_drain;

   assign w_drain = r_valid && ready_out;

   // A load on the draining edge wins, so the flag stays set with new data.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (load) begin
            r_data  <= data;
            r_valid <= 1'b1;
         end else if (w_drain) begin
            r_valid <= 1'b0;
         end
         if (w_drain)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign data_out   = r_data;
   assign valid_out  = r_valid;
   assign word_count = r_cnt;
endmodule

// File: rtl/demux_12_2bits_rr.sv
// 1:2 demultiplexer for the 2-bit datapath: lane picked by sel_ext or by a
// round-robin state that only advances on an accepted word.
module demux_12_2bits_rr
   import demux_12_2bits_rr_pkg::*;
#(
   parameter int DATA_W = `DEMUX_DATA_W,
   parameter int CNT_W  = `DEMUX_CNT_W
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_in,
   input  logic              sel_ext,
   input  logic              alt_mode,
   output logic [DATA_W-1:0] data_out0,
   output logic              valid_out0,
   input  logic              ready_out0,
   output logic [DATA_W-1:0] data_out1,
   output logic              valid_out1,
   input  logic              ready_out1,
   output logic [CNT_W-1:0]  word_count0,
   output logic [CNT_W-1:0]  word_count1
);
   logic [NUM_LANES-1:0]             w_load;
   logic [NUM_LANES-1:0]             w_valid;
   logic [NUM_LANES-1:0]             w_ready;
   logic [NUM_LANES-1:0][DATA_W-1:0] w_data;
   logic [NUM_LANES-1:0][CNT_W-1:0]  w_cnt;
   logic                             w_tgt;
   logic                             w_accept;
   rr_state_e                        r_state;

   assign w_ready  = {ready_out1, ready_out0};
   assign w_tgt    = alt_mode ? (r_state == LANE1) : sel_ext;
   assign ready_in = !w_valid[w_tgt] || w_ready[w_tgt];
   assign w_accept = valid_in && ready_in;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_load[g] = w_accept && (w_tgt == 1'(g));
      demux_lane_buffer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_buf (
         .clk        (clk),
         .reset_L    (reset_L),
         .load       (w_load[g]),
         .data       (data_in),
         .ready_out  (w_ready[g]),
         .data_out   (w_data[g]),
         .valid_out  (w_valid[g]),
         .word_count (w_cnt[g])
      );
   end

   // State holds while alt_mode=0 so re-enabling resumes where it left off.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         r_state <= LANE0;
      else if (alt_mode && w_accept)
         r_state <= rr_next(r_state);
   end

   assign data_out0   = w_data[0];
   assign data_out1   = w_data[1];
   assign valid_out0  = w_valid[0];
   assign valid_out1  = w_valid[1];
   assign word_count0 = w_cnt[0];
   assign word_count1 = w_cnt[1];
endmodule

// File: tb/tb_demux_12_2bits_rr.sv
// Directed bench for demux_12_2bits_rr with hand-computed expectations.
module tb_demux_12_2bits_rr;
   logic       clk = 1'b0;
   logic       reset_L;
   logic [1:0] data_in;
   logic       valid_in;
   logic       ready_in;
   logic       sel_ext;
   logic       alt_mode;
   logic [1:0] data_out0, data_out1;
   logic       valid_out0, valid_out1;
   logic       ready_out0, ready_out1;
   logic [3:0] word_count0, word_count1;

   int n_chk = 0;
   int n_err = 0;

   demux_12_2bits_rr #(.DATA_W(2), .CNT_W(4)) dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .ready_in    (ready_in),
      .sel_ext     (sel_ext),
      .alt_mode    (alt_mode),
      .data_out0   (data_out0),
      .valid_out0  (valid_out0),
      .ready_out0  (ready_out0),
      .data_out1   (data_out1),
      .valid_out1  (valid_out1),
      .ready_out1  (ready_out1),
      .word_count0 (word_count0),
      .word_count1 (word_count1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_L = 1'b0; data_in = 2'b11; valid_in = 1'b1;
      sel_ext = 1'b0; alt_mode = 1'b0; ready_out0 = 1'b0; ready_out1 = 1'b0;

      // reset held with valid_in asserted
      tick(); tick();
      chk("rst_vld0", valid_out0, 0);
      chk("rst_vld1", valid_out1, 0);
      chk("rst_dat0", data_out0, 0);
      chk("rst_dat1", data_out1, 0);
      chk("rst_cnt0", word_count0, 0);
      chk("rst_cnt1", word_count1, 0);
      chk("rst_rdy", ready_in, 1);
      valid_in = 1'b0;
      reset_L  = 1'b1;

      // fixed select to lane 1
      sel_ext = 1'b1; data_in = 2'b10; valid_in = 1'b1; ready_out1 = 1'b1;
      tick();
      valid_in = 1'b0;
      chk("fix_dat1", data_out1, 2'b10);
      chk("fix_vld1", valid_out1, 1);
      chk("fix_vld0", valid_out0, 0);
      tick();
      chk("fix_drain", valid_out1, 0);
      chk("fix_cnt1", word_count1, 1);
      chk("fix_hold", data_out1, 2'b10);

      // round-robin stream 0,1,2,3
      alt_mode = 1'b1; ready_out0 = 1'b1; ready_out1 = 1'b1; valid_in = 1'b1;
      data_in = 2'd0; tick(); chk("rr_w0", data_out0, 0); chk("rr_v0", valid_out0, 1);
      data_in = 2'd1; tick(); chk("rr_w1", data_out1, 1); chk("rr_v1", valid_out1, 1);
      data_in = 2'd2; tick(); chk("rr_w2", data_out0, 2);
      data_in = 2'd3; tick(); chk("rr_w3", data_out1, 3);
      valid_in = 1'b0;
      tick();
      chk("rr_cnt0", word_count0, 2);
      chk("rr_cnt1", word_count1, 3);

      // backpressure on lane 0
      alt_mode = 1'b0; sel_ext = 1'b0; ready_out0 = 1'b0; ready_out1 = 1'b0;
      data_in = 2'b01; valid_in = 1'b1;
      tick();
      chk("bp_first", data_out0, 2'b01);
      data_in = 2'b11;
      #1 chk("bp_rdy_lo", ready_in, 0);
      tick();
      chk("bp_hold", data_out0, 2'b01);
      ready_out0 = 1'b1;
      #1 chk("bp_rdy_hi", ready_in, 1);
      tick();
      chk("bp_reload", data_out0, 2'b11);
      chk("bp_vld", valid_out0, 1);
      chk("bp_cnt", word_count0, 3);
      valid_in = 1'b0;
      tick();
      chk("bp_empty", valid_out0, 0);
      chk("bp_cnt2", word_count0, 4);

      // FSM holds across alt_mode=0, resumes on LANE1
      ready_out1 = 1'b1;
      alt_mode = 1'b1; data_in = 2'd1; valid_in = 1'b1;
      tick(); chk("st_first", data_out0, 1);
      alt_mode = 1'b0; sel_ext = 1'b0;
      data_in = 2'd2; tick();
      data_in = 2'd3; tick();
      data_in = 2'd0; tick();
      chk("st_fix", data_out0, 0);
      chk("st_l1idle", valid_out1, 0);
      alt_mode = 1'b1; data_in = 2'd2;
      tick();
      valid_in = 1'b0;
      chk("st_resume_d", data_out1, 2);
      chk("st_resume_v", valid_out1, 1);
      chk("st_l0_keep", data_out0, 0);

      // mid-stream async reset with both lanes full
      ready_out0 = 1'b0; ready_out1 = 1'b0; alt_mode = 1'b0;
      valid_in = 1'b1; sel_ext = 1'b0; data_in = 2'd3; tick();
      sel_ext = 1'b1; tick();
      valid_in = 1'b0;
      chk("mid_full0", valid_out0, 1);
      chk("mid_full1", valid_out1, 1);
      #2 reset_L = 1'b0;
      #1;
      chk("mid_rst0", valid_out0, 0);
      chk("mid_rst1", valid_out1, 0);
      chk("mid_cnt0", word_count0, 0);
      #1 reset_L = 1'b1;

      // counter wrap after 16 deliveries on lane 0
      sel_ext = 1'b0; ready_out0 = 1'b1; valid_in = 1'b1;
      for (int i = 0; i < 16; i++) begin
         data_in = 2'(i);
         tick();
      end
      chk("wrap_15", word_count0, 15);
      valid_in = 1'b0;
      tick();
      chk("wrap_0", word_count0, 0);
      chk("wrap_l1", word_count1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
